// File: rtl/div_8bit.sv
// div_8bit: sequential restoring divider, one quotient bit per clock.
// Start/done handshake toward the control unit; results are registered and
// hold until the next accepted operation completes.
// Optional build macro DIV_SIGNED_EN adds the sgn input for two's-complement
// operands (magnitudes taken on accept, signs applied on the final edge).
module div_8bit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             sgn,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;     // latched divisor (magnitude)
  logic [WIDTH-1:0] racc_q, racc_d;   // partial remainder R
  logic [WIDTH-1:0] qacc_q, qacc_d;   // dividend/quotient shift register Q
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
`ifdef DIV_SIGNED_EN
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
`endif

  logic             accept;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] r_next, q_next;

  // Next-state, datapath and result capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    racc_d  = racc_q;
    qacc_d  = qacc_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
    negq_d  = negq_q;
    negr_d  = negr_q;
`endif

    accept = start && (state_q != S_RUN);

`ifdef DIV_SIGNED_EN
    a_mag = (sgn && dividend[WIDTH-1]) ? (~dividend + WIDTH'(1)) : dividend;
    b_mag = (sgn && divisor[WIDTH-1])  ? (~divisor + WIDTH'(1))  : divisor;
`else
    a_mag = dividend;
    b_mag = divisor;
`endif

    // Trial subtraction as add of the inverted divisor plus one; the
    // carry-out of the 9-bit sum set means the difference is non-negative.
    shifted = {racc_q[WIDTH-2:0], qacc_q[WIDTH-1]};
    trial   = {1'b0, shifted} + {1'b0, ~div_q} + (WIDTH+1)'(1);
    if (trial[WIDTH]) begin
      r_next = trial[WIDTH-1:0];
      q_next = {qacc_q[WIDTH-2:0], 1'b1};
    end else begin
      r_next = shifted;
      q_next = {qacc_q[WIDTH-2:0], 1'b0};
    end

    case (state_q)
      S_RUN: begin
        racc_d = r_next;
        qacc_d = q_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
          dbz_d   = 1'b0;
`ifdef DIV_SIGNED_EN
          quo_d   = negq_q ? (~q_next + WIDTH'(1)) : q_next;
          rem_d   = negr_q ? (~r_next + WIDTH'(1)) : r_next;
`else
          quo_d   = q_next;
          rem_d   = r_next;
`endif
        end
      end
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          if (divisor == '0) begin
            state_d = S_DONE;
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_RUN;
            div_d   = b_mag;
            racc_d  = '0;
            qacc_d  = a_mag;
            cnt_d   = '0;
`ifdef DIV_SIGNED_EN
            negq_d  = sgn && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            negr_d  = sgn && dividend[WIDTH-1];
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      racc_q  <= '0;
      qacc_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      racc_q  <= racc_d;
      qacc_q  <= qacc_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
      negq_q  <= negq_d;
      negr_q  <= negr_d;
`endif
    end
  end

  // busy/done decode straight from the state register (DONE lasts one cycle)
  always_comb begin
    busy        = (state_q == S_RUN);
    done        = (state_q == S_DONE);
    quotient    = quo_q;
    remainder   = rem_q;
    div_by_zero = dbz_q;
  end

endmodule

// File: tb/tb_div_8bit.sv
// Directed self-checking bench for div_8bit.
module tb_div_8bit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
`ifdef DIV_SIGNED_EN
  logic       sgn = 1'b0;
`endif
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;

  int errors = 0;
  int checks = 0;

  div_8bit #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
`ifdef DIV_SIGNED_EN
    .sgn(sgn),
`endif
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Waits (bounded) for done; lat counts edges after the call, 99 on timeout.
  task automatic wait_done(output int lat, output int busy_cycles);
    bit seen = 1'b0;
    lat = 0;
    busy_cycles = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) seen = 1'b1;
      else if (busy) busy_cycles++;
    end
    if (!seen) lat = 99;
  endtask

  task automatic test_reset();
    #1;
    checks++; if ({busy, done, div_by_zero} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {busy, done, div_by_zero}); end
    checks++; if ({quotient, remainder} !== 16'h0000) begin errors++; $display("FAIL reset_results got %h exp 0000", {quotient, remainder}); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat, bc;
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_after_accept got %b exp 1", busy); end
    wait_done(lat, bc);
    checks++; if (lat !== 8) begin errors++; $display("FAIL basic_latency got %0d exp 8", lat); end
    checks++; if (bc + 1 !== 8) begin errors++; $display("FAIL basic_busy_cycles got %0d exp 8", bc + 1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b exp 0", busy); end
    checks++; if ({quotient, remainder, div_by_zero} !== {8'd14, 8'd2, 1'b0}) begin errors++; $display("FAIL basic_result got q=%0d r=%0d z=%b exp q=14 r=2 z=0", quotient, remainder, div_by_zero); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b exp 0", done); end
    checks++; if (quotient !== 8'd14) begin errors++; $display("FAIL basic_hold got %0d exp 14", quotient); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a [3] = '{8'd255, 8'd3, 8'd0};
    logic [7:0] b [3] = '{8'd1, 8'd200, 8'd9};
    logic [7:0] eq [3] = '{8'd255, 8'd0, 8'd0};
    logic [7:0] er [3] = '{8'd0, 8'd3, 8'd0};
    int lat, bc;
    for (int i = 0; i < 3; i++) begin
      dividend = a[i]; divisor = b[i]; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL b2b_accept_%0d got busy,done=%b exp 10", i, {busy, done}); end
      wait_done(lat, bc);
      checks++; if (lat !== 8) begin errors++; $display("FAIL b2b_latency_%0d got %0d exp 8", i, lat); end
      checks++; if ({quotient, remainder} !== {eq[i], er[i]}) begin errors++; $display("FAIL b2b_result_%0d got q=%0d r=%0d exp q=%0d r=%0d", i, quotient, remainder, eq[i], er[i]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero();
    int bc = 0;
    dividend = 8'd5; divisor = 8'd0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    if (busy) bc++;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL dbz_done got %b exp 1", done); end
    checks++; if ({quotient, remainder, div_by_zero} !== {8'hFF, 8'd5, 1'b1}) begin errors++; $display("FAIL dbz_result got q=%h r=%h z=%b exp q=ff r=05 z=1", quotient, remainder, div_by_zero); end
    @(posedge clk); #1;
    if (busy) bc++;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL dbz_done_pulse got %b exp 0", done); end
    checks++; if (bc !== 0) begin errors++; $display("FAIL dbz_busy got %0d busy cycles exp 0", bc); end
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_hold got %b exp 1", div_by_zero); end
  endtask

  task automatic test_start_while_busy();
    int lat, bc, extra = 0;
    dividend = 8'd200; divisor = 8'd10; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    dividend = 8'd50; divisor = 8'd5; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(lat, bc);
    checks++; if (lat !== 5) begin errors++; $display("FAIL busy_start_latency got %0d exp 5", lat); end
    checks++; if ({quotient, remainder, div_by_zero} !== {8'd20, 8'd0, 1'b0}) begin errors++; $display("FAIL busy_start_result got q=%0d r=%0d z=%b exp q=20 r=0 z=0", quotient, remainder, div_by_zero); end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (busy || done) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL busy_start_ignored got %0d active cycles exp 0", extra); end
    checks++; if (quotient !== 8'd20) begin errors++; $display("FAIL busy_start_hold got %0d exp 20", quotient); end
  endtask

  task automatic test_reset_mid();
    int lat, bc, extra = 0;
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    checks++; if ({busy, done, div_by_zero, quotient, remainder} !== 19'd0) begin errors++; $display("FAIL rst_mid_clear got b=%b d=%b z=%b q=%h r=%h exp all 0", busy, done, div_by_zero, quotient, remainder); end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (busy || done) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL rst_mid_no_done got %0d active cycles exp 0", extra); end
    dividend = 8'd9; divisor = 8'd2; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(lat, bc);
    checks++; if (lat !== 8) begin errors++; $display("FAIL rst_fresh_latency got %0d exp 8", lat); end
    checks++; if ({quotient, remainder} !== {8'd4, 8'd1}) begin errors++; $display("FAIL rst_fresh_result got q=%0d r=%0d exp q=4 r=1", quotient, remainder); end
    @(posedge clk); #1;
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed();
    logic [7:0] a [4] = '{8'hF9, 8'h80, 8'hF9, 8'h85};
    logic [7:0] b [4] = '{8'h02, 8'hFF, 8'h02, 8'h00};
    logic       s [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] eq [4] = '{8'hFD, 8'h80, 8'h7C, 8'hFF};
    logic [7:0] er [4] = '{8'hFF, 8'h00, 8'h01, 8'h85};
    logic       ez [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      dividend = a[i]; divisor = b[i]; sgn = s[i]; start = 1'b1;
      @(posedge clk); #1; start = 1'b0; sgn = 1'b0;
      if (b[i] == 8'h00) lat = done ? 1 : 99;
      else wait_done(lat, bc);
      checks++; if (lat !== ((b[i] == 8'h00) ? 1 : 8)) begin errors++; $display("FAIL signed_latency_%0d got %0d", i, lat); end
      checks++; if ({quotient, remainder, div_by_zero} !== {eq[i], er[i], ez[i]}) begin errors++; $display("FAIL signed_result_%0d got q=%h r=%h z=%b exp q=%h r=%h z=%b", i, quotient, remainder, div_by_zero, eq[i], er[i], ez[i]); end
      @(posedge clk); #1;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_start_while_busy();
    test_reset_mid();
`ifdef DIV_SIGNED_EN
    test_signed();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_8bit.md
Name: div_8bit

Overview:
- Sequential 8-bit unsigned restoring divider: the inverse operation of the team's 8-bit add/sub block, for the CPU's DIV/MOD instructions.
- Produces quotient and remainder through repeated trial subtraction, one quotient bit per clock.
- Sits beside the ALU; the control unit drives it with a start/done handshake.

Parameters:
- WIDTH, 8, operand/result width; the only supported and verified value is 8.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only while idle or done.
- dividend  input  8  numerator; latched on accepted start.
- divisor  input  8  denominator; latched on accepted start.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse when results become valid.
- quotient  output  8  registered quotient; holds until the next accepted start completes.
- remainder  output  8  registered remainder; same hold rule as quotient.
- div_by_zero  output  1  high with done when divisor was 0; holds with the results.

Behaviour:
- Reset value of every output is 0 (busy, done, quotient, remainder, div_by_zero); FSM goes to IDLE; counter = 0.
- FSM states:
  - IDLE -> RUN on start with divisor != 0.
  - IDLE -> DONE on start with divisor == 0.
  - RUN -> DONE after 8 iterations.
  - DONE -> IDLE unconditionally, or DONE -> RUN/DONE if start is asserted in DONE (back-to-back accepted).
- Accept edge E0: latch divisor; partial remainder R = 0; shift register Q = dividend; counter = 0; busy = 1.
- Each RUN edge:
  - Form 9-bit T = {R[6:0],Q[7]} - {0,divisor}.
  - If T non-negative: R = T[7:0], shift 1 into Q.
  - Else: R = {R[6:0],Q[7]}, shift 0 into Q.
  - counter increments.
- At the 8th RUN edge (E8): quotient = Q, remainder = R, div_by_zero = 0, done = 1, busy = 0, state DONE.
  - Latency: done is high in the cycle after E8, i.e. 8 cycles after the accept edge.
- Divide by zero at E0: quotient = 8'hFF, remainder = dividend, div_by_zero = 1, done = 1 in the next cycle; busy stays 0.
- done is high for exactly one cycle; it clears at the next edge.
- start while busy is ignored; the operand inputs are don't-care during RUN.
- Asserting rst mid-operation immediately clears all state and outputs; the aborted operation never produces done.
- Trial subtraction reuses the 9-bit borrow convention of the add/sub block: the subtraction is non-negative when carry-out = 1.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- When defined:
  - Adds input port sgn (1 bit), sampled with start.
  - With sgn = 1, operands are two's complement. Magnitudes are taken at E0, and the result is negated at the final edge, so latency is unchanged.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - 8'h80 / 8'hFF gives quotient 8'h80, remainder 0.
  - Divide by zero with sgn = 1 gives quotient 8'hFF, remainder = dividend, div_by_zero = 1.
- When undefined: no sgn port; purely unsigned.

Test Plan:
- Basic divide: start with 100 / 7 -> done exactly 8 cycles after the accept edge, quotient 14, remainder 2, div_by_zero 0, busy high for 8 cycles.
- Boundary cases, run back-to-back with start held in DONE: 255 / 1 -> 255 r 0; 3 / 200 -> 0 r 3; 0 / 9 -> 0 r 0.
- Divide by zero: 5 / 0 -> done one cycle after the accept edge, quotient 8'hFF, remainder 5, div_by_zero 1, busy never high.
- Start while busy: pulse start with 50 / 5 at cycle 3 of a 200 / 10 run -> the 200 / 10 run completes with 20 r 0; 50 / 5 is not executed.
- Reset mid-operation: rst at cycle 4 of a run -> all outputs 0 immediately, no done; a fresh 9 / 2 afterwards -> 4 r 1.
- Signed (DIV_SIGNED_EN, sgn = 1):
  - 8'hF9 (-7) / 2 -> quotient 8'hFD (-3), remainder 8'hFF (-1).
  - 8'h80 / 8'hFF -> quotient 8'h80, remainder 0.
